// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants, the duty-update operation type and saturating arithmetic
// helpers for the multi-channel PWM controller.
//   PERIOD_DEF   : default counts per PWM period
//   DEB_DIV_DEF  : default clock cycles per debounce sample tick
//   DUTY_RST_DEF : default duty value after reset
//   LOAD_CH_W    : width of the direct-write channel index
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int unsigned PERIOD_DEF   = 10;
  localparam int unsigned DEB_DIV_DEF  = 2500000;
  localparam int unsigned DUTY_RST_DEF = 5;
  localparam int unsigned LOAD_CH_W    = 3;

  // What happens to a channel's shadow duty on the coming edge.
  typedef enum logic [1:0] {
    DUTY_HOLD,
    DUTY_LOAD,
    DUTY_INC,
    DUTY_DEC
  } duty_op_e;

  // Arithmetic is done in 32 bits so the sum can never wrap before clamping.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned step,
                                          input int unsigned lim);
    int unsigned s;
    s = a + step;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a,
                                          input int unsigned step);
    return (a > step) ? (a - step) : 32'd0;
  endfunction

  function automatic int unsigned clamp_max(input int unsigned a,
                                            input int unsigned lim);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// ---------------------------------------------------------------------------
// pwm_btn_debounce
// Turns one raw asynchronous button into at most one press event per
// debounce tick. The button is synchronised by two flops, sampled only on
// tick, and a press is a rising edge between two successive samples, so a
// held button produces exactly one event.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   tick_i  : one-cycle debounce sample strobe
//   btn_i   : raw button level (asynchronous)
//   press_o : one-cycle press event, valid in a tick cycle
// ---------------------------------------------------------------------------
module pwm_btn_debounce
  import pwm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic sample_q, prev_q;

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Slow sampling: the previous sample is kept to detect a rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else if (tick_i) begin
      sample_q <= sync2_q;
      prev_q   <= sample_q;
    end
  end

  // Gated by tick so the event lasts exactly one cycle per accepted edge.
  assign press_o = tick_i & sample_q & ~prev_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_multi_ctrl
// Multi-channel PWM controller. One shared period counter drives NUM_CH
// channels. Each channel has a shadow duty (adjusted by debounced inc/dec
// buttons or a direct load) and an active duty that copies the shadow only
// when the period counter wraps, keeping the outputs glitch-free.
// Ports:
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   ena_i          : global enable (counter runs, outputs allowed, buttons live)
//   inc_btn_i      : raw increment buttons, one per channel
//   dec_btn_i      : raw decrement buttons, one per channel
//   load_valid_i   : direct duty write strobe
//   load_ch_i      : channel index for the direct write
//   load_duty_i    : duty value for the direct write (clamped to PERIOD)
//   pwm_out_o      : registered PWM outputs
//   duty_out_o     : active duty per channel, channel 0 in the LSBs
//   period_start_o : one-cycle pulse when the counter enters 0
// ---------------------------------------------------------------------------
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PERIOD   = PERIOD_DEF,
  parameter int unsigned DUTY_RST = DUTY_RST_DEF,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DEB_DIV  = DEB_DIV_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ena_i,
  input  logic [NUM_CH-1:0]       inc_btn_i,
  input  logic [NUM_CH-1:0]       dec_btn_i,
  input  logic                    load_valid_i,
  input  logic [LOAD_CH_W-1:0]    load_ch_i,
  input  logic [CNT_W-1:0]        load_duty_i,
  output logic [NUM_CH-1:0]       pwm_out_o,
  output logic [NUM_CH*CNT_W-1:0] duty_out_o,
  output logic                    period_start_o
);

  localparam int unsigned DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap;

  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  duty_op_e          op       [NUM_CH];

  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_start_q, period_start_d;

  logic [NUM_CH-1:0] inc_press, dec_press;
  logic [NUM_CH-1:0] inc_ev, dec_ev;

  // Debounce tick divider; free-runs independent of the enable.
  assign tick  = (div_q == DIV_W'(DEB_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // One debouncer per button.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_btn
    pwm_btn_debounce u_inc_deb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .tick_i  (tick),
      .btn_i   (inc_btn_i[g]),
      .press_o (inc_press[g])
    );
    pwm_btn_debounce u_dec_deb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .tick_i  (tick),
      .btn_i   (dec_btn_i[g]),
      .press_o (dec_press[g])
    );
  end

  // Button events are dropped while disabled; loads are not.
  assign inc_ev = inc_press & {NUM_CH{ena_i}};
  assign dec_ev = dec_press & {NUM_CH{ena_i}};

  // Shared period counter; holds while disabled.
  always_comb begin
    wrap  = ena_i && (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (ena_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Per-channel shadow update (load beats buttons, inc+dec together cancel)
  // and active duty reload at the wrap.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      op[ch]       = DUTY_HOLD;
      shadow_d[ch] = shadow_q[ch];
      active_d[ch] = wrap ? shadow_q[ch] : active_q[ch];

      if (load_valid_i && (load_ch_i == LOAD_CH_W'(ch))) begin
        op[ch] = DUTY_LOAD;
      end else if (inc_ev[ch] && !dec_ev[ch]) begin
        op[ch] = DUTY_INC;
      end else if (dec_ev[ch] && !inc_ev[ch]) begin
        op[ch] = DUTY_DEC;
      end

      case (op[ch])
        DUTY_LOAD: shadow_d[ch] = CNT_W'(clamp_max(32'(load_duty_i), PERIOD));
        DUTY_INC:  shadow_d[ch] = CNT_W'(sat_add(32'(shadow_q[ch]), STEP, PERIOD));
        DUTY_DEC:  shadow_d[ch] = CNT_W'(sat_sub(32'(shadow_q[ch]), STEP));
        default:   shadow_d[ch] = shadow_q[ch];
      endcase
    end
  end

  // Outputs are computed from next-state values so the registered output
  // lines up with the registered counter.
  always_comb begin
    pwm_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pwm_d[ch] = ena_i && (cnt_d < active_d[ch]);
    end
    period_start_d = wrap;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q          <= '0;
      cnt_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= CNT_W'(DUTY_RST);
        active_q[ch] <= CNT_W'(DUTY_RST);
      end
    end else begin
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= shadow_d[ch];
        active_q[ch] <= active_d[ch];
      end
    end
  end

  // Pack active duties, channel 0 in the LSBs.
  always_comb begin
    duty_out_o = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      duty_out_o[ch*CNT_W +: CNT_W] = active_q[ch];
    end
  end

  assign pwm_out_o      = pwm_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_ctrl
// Scoreboard bench for pwm_multi_ctrl. The driver applies one set of inputs
// per cycle, advances a behavioural model of the controller and queues the
// outputs expected for that cycle; a monitor on the falling edge pops and
// compares. Button presses are modelled from the raw button history: a tick
// sees the level from two cycles earlier, and an event is a 0->1 change
// between consecutive tick samples.
// ---------------------------------------------------------------------------
module tb_pwm_multi_ctrl;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 4;
  localparam int PERIOD   = 10;
  localparam int DUTY_RST = 5;
  localparam int STEP     = 1;
  localparam int DEB      = 4;
  localparam int HIST     = 8192;

  typedef struct {
    logic [NUM_CH-1:0]       pwm;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic                    ps;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rstN = 1'b0;
  logic                    ena = 1'b0;
  logic [NUM_CH-1:0]       incBtn = '0;
  logic [NUM_CH-1:0]       decBtn = '0;
  logic                    loadValid = 1'b0;
  logic [2:0]              loadCh = '0;
  logic [CNT_W-1:0]        loadDuty = '0;
  logic [NUM_CH-1:0]       pwmOut;
  logic [NUM_CH*CNT_W-1:0] dutyOut;
  logic                    periodStart;

  int testsRun = 0;
  int testsFailed = 0;

  exp_t expQ[$];

  // Behavioural model state
  int mC;
  int mCnt;
  int mShadow [NUM_CH];
  int mActive [NUM_CH];
  bit mPrevEna;
  bit mPrevWrap;
  bit [NUM_CH-1:0] incHist [HIST];
  bit [NUM_CH-1:0] decHist [HIST];

  pwm_multi_ctrl #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PERIOD   (PERIOD),
    .DUTY_RST (DUTY_RST),
    .STEP     (STEP),
    .DEB_DIV  (DEB)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .ena_i          (ena),
    .inc_btn_i      (incBtn),
    .dec_btn_i      (decBtn),
    .load_valid_i   (loadValid),
    .load_ch_i      (loadCh),
    .load_duty_i    (loadDuty),
    .pwm_out_o      (pwmOut),
    .duty_out_o     (dutyOut),
    .period_start_o (periodStart)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic bit histBit(input bit isInc, input int idx, input int ch);
    if (idx < 0 || idx >= HIST) return 1'b0;
    return isInc ? incHist[idx][ch] : decHist[idx][ch];
  endfunction

  task automatic modelReset();
    mC = 0;
    mCnt = 0;
    mPrevEna = 1'b0;
    mPrevWrap = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mShadow[ch] = DUTY_RST;
      mActive[ch] = DUTY_RST;
    end
    for (int i = 0; i < HIST; i++) begin
      incHist[i] = '0;
      decHist[i] = '0;
    end
  endtask

  // One cycle of the model, using the inputs currently driven.
  task automatic modelCycle();
    exp_t e;
    bit wrap;
    bit incEv, decEv, isTick;
    e.pwm = '0;
    e.duty = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e.pwm[ch] = mPrevEna && (mCnt < mActive[ch]);
      e.duty[ch*CNT_W +: CNT_W] = CNT_W'(mActive[ch]);
    end
    e.ps = mPrevWrap;
    expQ.push_back(e);

    if (mC < HIST) begin
      incHist[mC] = incBtn;
      decHist[mC] = decBtn;
    end
    isTick = ((mC % DEB) == DEB - 1);
    wrap = ena && (mCnt == PERIOD - 1);

    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wrap) mActive[ch] = mShadow[ch];
      incEv = isTick && ena && histBit(1'b1, mC - DEB - 2, ch) && !histBit(1'b1, mC - 2*DEB - 2, ch);
      decEv = isTick && ena && histBit(1'b0, mC - DEB - 2, ch) && !histBit(1'b0, mC - 2*DEB - 2, ch);
      if (loadValid && int'(loadCh) == ch)
        mShadow[ch] = (int'(loadDuty) > PERIOD) ? PERIOD : int'(loadDuty);
      else if (incEv && decEv)
        mShadow[ch] = mShadow[ch];
      else if (incEv)
        mShadow[ch] = (mShadow[ch] + STEP > PERIOD) ? PERIOD : mShadow[ch] + STEP;
      else if (decEv)
        mShadow[ch] = (mShadow[ch] - STEP < 0) ? 0 : mShadow[ch] - STEP;
    end

    if (ena) mCnt = wrap ? 0 : mCnt + 1;
    mPrevEna = ena;
    mPrevWrap = wrap;
    mC++;
  endtask

  task automatic applyStimulus(input logic en, input logic [NUM_CH-1:0] inc,
                               input logic [NUM_CH-1:0] dec, input logic lv,
                               input logic [2:0] lch, input logic [CNT_W-1:0] ld);
    @(posedge clk);
    #1;
    ena = en;
    incBtn = inc;
    decBtn = dec;
    loadValid = lv;
    loadCh = lch;
    loadDuty = ld;
    modelCycle();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, '0, '0, 1'b0, 3'd0, '0);
  endtask

  task automatic pressBtn(input int ch, input bit isInc, input int hold, input int gap);
    logic [NUM_CH-1:0] b;
    b = '0;
    b[ch] = 1'b1;
    repeat (hold) applyStimulus(1'b1, isInc ? b : '0, isInc ? '0 : b, 1'b0, 3'd0, '0);
    idle(gap);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
    modelCycle();
  endtask

  task automatic checkValue(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("pwm_out", int'(pwmOut), int'(e.pwm));
    checkValue("duty_out", int'(dutyOut), int'(e.duty));
    checkValue("period_start", int'(periodStart), int'(e.ps));
  endtask

  // Asynchronous reset mid-period: outputs must change before any clock edge.
  task automatic resetPulse();
    logic [NUM_CH*CNT_W-1:0] rstDuty;
    for (int ch = 0; ch < NUM_CH; ch++) rstDuty[ch*CNT_W +: CNT_W] = CNT_W'(DUTY_RST);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    expQ.delete();
    #1;
    checkValue("async_rst_pwm", int'(pwmOut), 0);
    checkValue("async_rst_duty", int'(dutyOut), int'(rstDuty));
    checkValue("async_rst_ps", int'(periodStart), 0);
    @(posedge clk);
    releaseReset();
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rstN && expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    modelReset();
    $display("[TB] start");
    repeat (2) @(posedge clk);
    ena = 1'b1;
    releaseReset();

    // Default operation at duty 5 on both channels.
    idle(30);

    // Long hold on inc[0] gives a single step.
    pressBtn(0, 1'b1, 40, 24);

    // Saturate up, then down.
    for (int i = 0; i < 6; i++) pressBtn(0, 1'b1, 8, 12);
    idle(22);
    for (int i = 0; i < 11; i++) pressBtn(0, 1'b0, 8, 12);
    idle(22);

    // inc and dec together on ch1 cancel.
    repeat (10) applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 3'd0, '0);
    idle(12);

    // Load to ch1 overlapping a ch1 press: clamped load wins.
    repeat (8) applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 3'd1, 4'd13);
    idle(12);

    // Load to a non-existent channel.
    applyStimulus(1'b1, '0, '0, 1'b1, 3'd5, 4'd3);
    idle(12);

    // Load ch0 in the last cycle of a period.
    for (int i = 0; i < 2*PERIOD && mCnt != PERIOD - 1; i++) idle(1);
    applyStimulus(1'b1, '0, '0, 1'b1, 3'd0, 4'd2);
    idle(25);

    // Disable mid-period, then resume.
    for (int i = 0; i < 2*PERIOD && mCnt != 4; i++) idle(1);
    repeat (7) applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, '0);
    idle(20);

    // Randomised traffic.
    begin
      logic [NUM_CH-1:0] incL, decL;
      logic en, lv;
      incL = '0;
      decL = '0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 11) == 0) incL = NUM_CH'($urandom);
        if ($urandom_range(0, 11) == 0) decL = NUM_CH'($urandom);
        en = ($urandom_range(0, 15) != 0);
        lv = ($urandom_range(0, 9) == 0);
        applyStimulus(en, incL, decL, lv, 3'($urandom_range(0, 7)),
                      CNT_W'($urandom_range(0, 15)));
      end
    end
    idle(12);

    // Reset pulse mid-period.
    for (int i = 0; i < 2*PERIOD && mCnt != 3; i++) idle(1);
    resetPulse();
    idle(25);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
